// File: rtl/treino_pkg.sv
// Shared constants, state encoding and half-precision helpers for the
// perceptron training sequencer.
package treino_pkg;

   localparam int unsigned HALF_W = 16;

   localparam logic [HALF_W-1:0] HALF_ONE   = 16'h3C00;
   localparam logic [HALF_W-1:0] HALF_ZERO  = 16'h0000;
   localparam logic [HALF_W-1:0] HALF_NZERO = 16'h8000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_AVAL,
      ST_ATUALIZA,
      ST_DONE
   } estado_t;

   // Exponent field saturated: value is NaN or +/-Inf.
   function automatic logic half_nan_inf(input logic [HALF_W-1:0] x);
      return x[14:10] == 5'h1F;
   endfunction

   // Bitwise equality, except that +0 and -0 compare equal.
   function automatic logic half_eq(input logic [HALF_W-1:0] a,
                                    input logic [HALF_W-1:0] b);
      return (a == b) || ((a[14:0] == 15'd0) && (b[14:0] == 15'd0));
   endfunction

endpackage

// File: rtl/conta_erros.sv
// Counts how many of the four epoch-stage outputs differ from their targets.
module conta_erros
   import treino_pkg::*;
(
   input  logic [3:0][HALF_W-1:0] d,
   input  logic [3:0][HALF_W-1:0] result,
   output logic [2:0]             cnt_c
);

   always_comb begin
      cnt_c = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!half_eq(result[i], d[i])) begin
            cnt_c = cnt_c + 3'd1;
         end
      end
   end

endmodule

// File: rtl/seq_treino.sv
// Epoch sequencer: holds the weights, waits for the epoch stage to settle,
// evaluates its outputs and either captures updated weights or stops.
module seq_treino
   import treino_pkg::*;
#(
   parameter int unsigned tam        = 16,
   parameter int unsigned MAX_EPOCAS = 10,
   parameter int unsigned SETTLE     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [tam-1:0]      w0_init,
   input  logic [tam-1:0]      w1_init,
   input  logic [tam-1:0]      w2_init,
   input  logic [3:0][tam-1:0] d,
   output logic [tam-1:0]      w0,
   output logic [tam-1:0]      w1,
   output logic [tam-1:0]      w2,
   input  logic [tam-1:0]      w0_upd,
   input  logic [tam-1:0]      w1_upd,
   input  logic [tam-1:0]      w2_upd,
   input  logic [3:0][tam-1:0] result,
   output logic                busy,
   output logic                done,
   output logic                convergiu,
   output logic                fp_err,
   output logic [3:0]          epocas,
   output logic [2:0]          erros
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] SETTLE_ULT = CW'(SETTLE - 1);
   localparam logic [3:0]    EPOCA_ULT  = 4'(MAX_EPOCAS - 1);

   estado_t       state;
   logic [CW-1:0] cont;
   logic [2:0]    cnt_c;
   logic          fault_c;

   conta_erros u_conta_erros (
      .d      (d),
      .result (result),
      .cnt_c  (cnt_c)
   );

   assign fault_c = half_nan_inf(w0_upd) | half_nan_inf(w1_upd) | half_nan_inf(w2_upd);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cont      <= '0;
         w0        <= '0;
         w1        <= '0;
         w2        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         convergiu <= 1'b0;
         fp_err    <= 1'b0;
         epocas    <= 4'd0;
         erros     <= 3'd0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state <= ST_LOAD;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            ST_LOAD: begin
               w0        <= w0_init;
               w1        <= w1_init;
               w2        <= w2_init;
               epocas    <= 4'd0;
               erros     <= 3'd0;
               convergiu <= 1'b0;
               fp_err    <= 1'b0;
               cont      <= '0;
               state     <= ST_SETTLE;
            end
            ST_SETTLE: begin
               cont <= cont + CW'(1);
               if (cont == SETTLE_ULT) begin
                  state <= ST_AVAL;
               end
            end
            ST_AVAL: begin
               epocas <= epocas + 4'd1;
               erros  <= cnt_c;
               // Exit priority: convergence, then FP fault, then epoch limit.
               if (cnt_c == 3'd0) begin
                  convergiu <= 1'b1;
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else if (fault_c) begin
                  fp_err <= 1'b1;
                  state  <= ST_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else if (epocas == EPOCA_ULT) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= ST_ATUALIZA;
               end
            end
            ST_ATUALIZA: begin
               w0    <= w0_upd;
               w1    <= w1_upd;
               w2    <= w2_upd;
               cont  <= '0;
               state <= ST_SETTLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_treino.sv
// Self-checking bench for seq_treino with a table-driven epoch-stage model.
module tb_seq_treino;

   localparam int S   = 4;
   localparam int MAX = 10;
   localparam int EP  = S + 2;

   logic              clk = 1'b0;
   logic              rst, start;
   logic [15:0]       w0_init, w1_init, w2_init;
   logic [3:0][15:0]  d, result;
   logic [15:0]       w0, w1, w2, w0_upd, w1_upd, w2_upd;
   logic              busy, done, convergiu, fp_err;
   logic [3:0]        epocas;
   logic [2:0]        erros;

   int checks = 0;
   int errors = 0;

   // Epoch-stage behaviour, one row per epoch
   logic [15:0] t_res  [MAX][4];
   logic [15:0] t_upd  [MAX][3];
   logic [15:0] t_init [3];

   int          m_ep;
   int          m_cnt [MAX];
   bit          m_conv, m_fp;
   logic [15:0] m_w [3];

   seq_treino #(.tam(16), .MAX_EPOCAS(MAX), .SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start),
      .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init), .d(d),
      .w0(w0), .w1(w1), .w2(w2),
      .w0_upd(w0_upd), .w1_upd(w1_upd), .w2_upd(w2_upd), .result(result),
      .busy(busy), .done(done), .convergiu(convergiu), .fp_err(fp_err),
      .epocas(epocas), .erros(erros)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] norm(input logic [15:0] x);
      return (x == 16'h8000) ? 16'h0000 : x;
   endfunction

   function automatic bit is_fault(input logic [15:0] x);
      return x[14:10] == 5'b11111;
   endfunction

   // Training outcome from the rules: count mismatches, stop on success, fault or limit.
   task automatic model();
      m_w = t_init; m_conv = 0; m_fp = 0; m_ep = 0;
      for (int e = 0; e < MAX; e++) begin
         int cnt = 0;
         for (int l = 0; l < 4; l++)
            if (norm(t_res[e][l]) != norm(d[l])) cnt++;
         m_cnt[e] = cnt;
         m_ep = e + 1;
         if (cnt == 0) begin m_conv = 1; break; end
         if (is_fault(t_upd[e][0]) || is_fault(t_upd[e][1]) || is_fault(t_upd[e][2])) begin
            m_fp = 1; break;
         end
         if (e == MAX - 1) break;
         m_w[0] = t_upd[e][0]; m_w[1] = t_upd[e][1]; m_w[2] = t_upd[e][2];
      end
   endtask

   task automatic drive(input int idx);
      for (int l = 0; l < 4; l++) result[l] = t_res[idx][l];
      w0_upd = t_upd[idx][0]; w1_upd = t_upd[idx][1]; w2_upd = t_upd[idx][2];
   endtask

   task automatic fill(input logic [15:0] r, input logic [15:0] u);
      for (int e = 0; e < MAX; e++) begin
         for (int l = 0; l < 4; l++) t_res[e][l] = r;
         for (int j = 0; j < 3; j++) t_upd[e][j] = u + 16'(e);
      end
   endtask

   task automatic set_res_d(input int e);
      for (int l = 0; l < 4; l++) t_res[e][l] = d[l];
   endtask

   task automatic run_scenario(input string name, input bit poke_start);
      int total;
      model();
      total = m_ep * EP;
      @(negedge clk);
      w0_init = t_init[0]; w1_init = t_init[1]; w2_init = t_init[2];
      drive(0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= total; c++) begin
         int idx = (c < 2) ? 0 : (c - 2) / EP;
         if (idx > MAX - 1) idx = MAX - 1;
         drive(idx);
         start = (poke_start && (c == 3 || c == EP + 1)) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
         checks++;
         if (c < total) begin
            if ({busy, done} !== 2'b10) begin
               errors++;
               $display("FAIL %s busy/done c=%0d got %b expected 10", name, c, {busy, done});
            end
         end else if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL %s done-timing c=%0d got %b expected 01", name, c, {busy, done});
         end
         if (c == 1) begin
            checks++;
            if ({w0, w1, w2} !== {t_init[0], t_init[1], t_init[2]}) begin
               errors++;
               $display("FAIL %s load-weights got %h %h %h expected %h %h %h", name,
                        w0, w1, w2, t_init[0], t_init[1], t_init[2]);
            end
         end
         if (c % EP == 0 && c < total) begin
            int e = c / EP;
            checks++;
            if (epocas !== 4'(e) || erros !== 3'(m_cnt[e-1])) begin
               errors++;
               $display("FAIL %s epoch-%0d counters got ep=%0d err=%0d expected ep=%0d err=%0d",
                        name, e, epocas, erros, e, m_cnt[e-1]);
            end
         end
         if (c % EP == 1 && c > EP) begin
            int e = (c - 1) / EP;
            checks++;
            if ({w0, w1, w2} !== {t_upd[e-1][0], t_upd[e-1][1], t_upd[e-1][2]}) begin
               errors++;
               $display("FAIL %s update-%0d got %h %h %h expected %h %h %h", name, e,
                        w0, w1, w2, t_upd[e-1][0], t_upd[e-1][1], t_upd[e-1][2]);
            end
         end
      end
      checks++;
      if (convergiu !== m_conv || fp_err !== m_fp || epocas !== 4'(m_ep) ||
          erros !== 3'(m_cnt[m_ep-1])) begin
         errors++;
         $display("FAIL %s final-flags got conv=%b fp=%b ep=%0d err=%0d expected conv=%b fp=%b ep=%0d err=%0d",
                  name, convergiu, fp_err, epocas, erros, m_conv, m_fp, m_ep, m_cnt[m_ep-1]);
      end
      checks++;
      if ({w0, w1, w2} !== {m_w[0], m_w[1], m_w[2]}) begin
         errors++;
         $display("FAIL %s final-weights got %h %h %h expected %h %h %h", name,
                  w0, w1, w2, m_w[0], m_w[1], m_w[2]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || epocas !== 4'(m_ep)) begin
         errors++;
         $display("FAIL %s done-hold got done=%b busy=%b ep=%0d expected done=1 busy=0 ep=%0d",
                  name, done, busy, epocas, m_ep);
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({w0, w1, w2, busy, done, convergiu, fp_err, epocas, erros} !== '0) begin
         errors++;
         $display("FAIL %s outputs got w=%h %h %h busy=%b done=%b conv=%b fp=%b ep=%0d err=%0d expected all 0",
                  name, w0, w1, w2, busy, done, convergiu, fp_err, epocas, erros);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
   endtask

   task automatic test_converge();
      t_init = '{16'h3800, 16'h3800, 16'h3800};
      fill(16'h0000, 16'h4000);
      for (int e = 0; e < MAX; e++) set_res_d(e);
      run_scenario("converge", 1'b0);
   endtask

   task automatic test_two_epochs();
      t_init = '{16'h3800, 16'h3800, 16'h3800};
      fill(16'h0000, 16'h4000);
      t_upd[0] = '{16'h3C00, 16'h3800, 16'h3800};
      for (int e = 1; e < MAX; e++) set_res_d(e);
      run_scenario("two_epochs", 1'b0);
   endtask

   task automatic test_limit();
      t_init = '{16'h3400, 16'h3500, 16'h3600};
      fill(16'h0000, 16'h4100);
      run_scenario("limit", 1'b0);
   endtask

   task automatic test_fp_fault();
      t_init = '{16'h3800, 16'h3555, 16'h3800};
      fill(16'h0000, 16'h4000);
      t_upd[0] = '{16'h3800, 16'h7C00, 16'h3800};
      run_scenario("fp_fault", 1'b0);
   endtask

   task automatic test_signed_zero();
      t_init = '{16'h3000, 16'h3100, 16'h3200};
      fill(16'h0000, 16'h4200);
      set_res_d(0); t_res[0][0] = 16'h8000; t_res[0][3] = 16'h0000;
      set_res_d(1); t_res[1][0] = 16'h8000;
      run_scenario("signed_zero_start_busy", 1'b1);
   endtask

   task automatic test_rst_mid();
      test_limit();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst_idle");
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         for (int l = 0; l < 4; l++) d[l] = ($urandom_range(0, 1) != 0) ? 16'h3C00 : 16'h0000;
         for (int j = 0; j < 3; j++) t_init[j] = 16'($urandom);
         for (int e = 0; e < MAX; e++) begin
            for (int l = 0; l < 4; l++) begin
               if ($urandom_range(0, 3) != 0)
                  t_res[e][l] = (d[l] == 16'h0000 && $urandom_range(0, 1) != 0) ? 16'h8000 : d[l];
               else
                  t_res[e][l] = 16'($urandom);
            end
            for (int j = 0; j < 3; j++) begin
               t_upd[e][j] = 16'($urandom);
               if (t_upd[e][j][14:10] == 5'h1F) t_upd[e][j][14] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) t_upd[e][$urandom_range(0, 2)][14:10] = 5'h1F;
         end
         run_scenario("random", ($urandom_range(0, 1) != 0));
      end
      d = {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000};
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      w0_init = '0; w1_init = '0; w2_init = '0;
      w0_upd = '0; w1_upd = '0; w2_upd = '0;
      result = '0;
      d = {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000};
      test_reset();
      test_converge();
      test_two_epochs();
      test_limit();
      test_fp_fault();
      test_signed_zero();
      test_rst_mid();
      test_random();
      test_converge();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
